// File: rtl/key_pkg.sv
// Shared constants for the 256-line key encoder.
// Key codes follow ASCII for 0..127; 128..255 are extended keys.
package key_pkg;
  localparam int N_IN   = 256;
  localparam int CODE_W = 8;
  localparam int GRP_W  = 16;
  localparam int N_GRP  = N_IN / GRP_W;

  localparam logic [CODE_W-1:0] KEY_NUL  = 8'd0;
  localparam logic [CODE_W-1:0] KEY_LF   = 8'd10;
  localparam logic [CODE_W-1:0] KEY_OP   = 8'd40;
  localparam logic [CODE_W-1:0] KEY_CP   = 8'd41;
  localparam logic [CODE_W-1:0] KEY_A_LC = 8'd97;
  localparam logic [CODE_W-1:0] KEY_B_LC = 8'd98;
  localparam logic [CODE_W-1:0] KEY_S_LC = 8'd115;
  localparam logic [CODE_W-1:0] KEY_X_LC = 8'd120;
endpackage

// File: rtl/prio_enc16.sv
// 16-input MSB-priority encoder, purely combinational.
// o_vld flags that any input is set.
module prio_enc16 (
  input  logic [15:0] i_in,
  output logic [3:0]  o_idx,
  output logic        o_vld
);
  always_comb begin
    o_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (i_in[i]) o_idx = 4'(i);
    end
  end

  assign o_vld = |i_in;
endmodule

// File: rtl/key_encoder.sv
// One-hot key matrix to registered code; highest key wins.
// KEY_ENCODER_MULTI_DET_EN adds a registered multi-key flag.
module key_encoder
  import key_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [N_IN-1:0]   keys,
  output logic [CODE_W-1:0] char,
`ifdef KEY_ENCODER_MULTI_DET_EN
  output logic              multi,
`endif
  output logic              pak
);
  logic [3:0]       w_grp_idx [N_GRP];
  logic [N_GRP-1:0] w_grp_vld;
  logic [3:0]       w_hi;
  logic [3:0]       w_lo;
  logic             w_any;

  for (genvar g = 0; g < N_GRP; g++) begin : g_grp
    prio_enc16 u_lvl1 (
      .i_in  (keys[g*GRP_W +: GRP_W]),
      .o_idx (w_grp_idx[g]),
      .o_vld (w_grp_vld[g])
    );
  end

  // Second level picks the group; its valid is the OR of all groups.
  prio_enc16 u_lvl2 (
    .i_in  (w_grp_vld),
    .o_idx (w_hi),
    .o_vld (w_any)
  );

  assign w_lo = w_grp_idx[w_hi];

  always_ff @(posedge clk) begin
    if (rst) begin
      char <= '0;
      pak  <= 1'b0;
    end else begin
      char <= {w_hi, w_lo};
      pak  <= w_any;
    end
  end

`ifdef KEY_ENCODER_MULTI_DET_EN
  logic [N_GRP-1:0] w_grp_multi;
  logic             w_multi;

  // Two keys: either two in one group, or two groups active.
  for (genvar g = 0; g < N_GRP; g++) begin : g_mul
    assign w_grp_multi[g] =
      |(keys[g*GRP_W +: GRP_W] & (keys[g*GRP_W +: GRP_W] - 16'd1));
  end

  assign w_multi = (|w_grp_multi) |
                   (|(w_grp_vld & (w_grp_vld - 16'd1)));

  always_ff @(posedge clk) begin
    if (rst) multi <= 1'b0;
    else     multi <= w_multi;
  end
`endif
endmodule

// File: tb/tb_key_encoder.sv
// Scoreboard bench for key_encoder.
// Build with KEY_ENCODER_MULTI_DET_EN to also check multi.
module tb_key_encoder;
  import key_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic [N_IN-1:0]   keys;
  logic [CODE_W-1:0] char;
  logic              pak;
`ifdef KEY_ENCODER_MULTI_DET_EN
  logic              multi;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    string             tag;
    logic [CODE_W-1:0] ch;
    logic              pk;
    logic              mu;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  key_encoder dut (
    .clk  (clk),
    .rst  (rst),
    .keys (keys),
    .char (char),
`ifdef KEY_ENCODER_MULTI_DET_EN
    .multi(multi),
`endif
    .pak  (pak)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N_IN-1:0] oh(input int i);
    logic [N_IN-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Drive one cycle, push the expectation, compare after the edge.
  task automatic step(input string tag, input logic [N_IN-1:0] k,
                      input logic r, input logic [7:0] ec,
                      input logic ep, input logic em);
    exp_t e;
    keys = k;
    rst  = r;
    q.push_back('{tag, ec, ep, em});
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      chk("q_empty", 32'd1, 32'd0);
    end else begin
      e = q.pop_front();
      chk({e.tag, "_char"}, 32'(char), 32'(e.ch));
      chk({e.tag, "_pak"}, 32'(pak), 32'(e.pk));
`ifdef KEY_ENCODER_MULTI_DET_EN
      chk({e.tag, "_multi"}, 32'(multi), 32'(e.mu));
`endif
    end
  endtask

  task automatic single(input string tag, input logic [7:0] c);
    step(tag, oh(int'(c)), 1'b0, c, 1'b1, 1'b0);
    step({tag, "_rel"}, '0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    int idx;
    keys = '0;
    rst  = 1'b1;

    step("rst0", oh(97), 1'b1, 8'h00, 1'b0, 1'b0);
    step("rst1", oh(97), 1'b1, 8'h00, 1'b0, 1'b0);
    step("post_rst", oh(97), 1'b0, 8'h61, 1'b1, 1'b0);
    step("idle", '0, 1'b0, 8'h00, 1'b0, 1'b0);

    single("a", KEY_A_LC);
    single("b", KEY_B_LC);
    single("s", KEY_S_LC);
    single("op", KEY_OP);
    single("x", KEY_X_LC);
    single("cp", KEY_CP);
    single("lf", KEY_LF);

    step("nul", oh(int'(KEY_NUL)), 1'b0, 8'h00, 1'b1, 1'b0);
    step("nul_rel", '0, 1'b0, 8'h00, 1'b0, 1'b0);

    step("pri_a_lf", oh(97) | oh(10), 1'b0, 8'h61, 1'b1, 1'b1);
    step("pri_ff_00", oh(255) | oh(0), 1'b0, 8'hFF, 1'b1, 1'b1);
    step("pri_same_grp", oh(17) | oh(18), 1'b0, 8'h12, 1'b1, 1'b1);

    step("b15", oh(15), 1'b0, 8'd15, 1'b1, 1'b0);
    step("b16", oh(16), 1'b0, 8'd16, 1'b1, 1'b0);
    step("b127", oh(127), 1'b0, 8'd127, 1'b1, 1'b0);
    step("b128", oh(128), 1'b0, 8'd128, 1'b1, 1'b0);
    step("b240", oh(240), 1'b0, 8'd240, 1'b1, 1'b0);
    step("b255", oh(255), 1'b0, 8'd255, 1'b1, 1'b0);
    step("hold255", oh(255), 1'b0, 8'd255, 1'b1, 1'b0);

    for (int i = 0; i < 24; i++) begin
      idx = int'($urandom_range(0, N_IN - 1));
      if (i == 12)
        step("rnd_rst", oh(idx), 1'b1, 8'h00, 1'b0, 1'b0);
      else
        step("rnd", oh(idx), 1'b0, 8'(idx), 1'b1, 1'b0);
    end

    step("end_rel", '0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("q_drained", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/key_encoder.md
Name: key_encoder

Overview:
- 256-line one-hot key-matrix encoder for the MiniComputer keyboard path.
- Input bit i is the key whose ASCII/extended code is i: bit 0 = NUL, bit 10 = LF, bit 97 = 'a', bits 128..255 = extended "other" keys.
- Produces a registered 8-bit character code plus a key-present flag; the keyboard wrapper consumes both.

Parameters:
- N_IN, 256, number of key lines; must be a power of two, 256 in this design.
- CODE_W, 8, output code width; equals log2(N_IN).

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst, input, 1, synchronous active-high reset.
- keys, input, N_IN, key lines; bit i asserted means the key with code i is pressed.
- char, output, CODE_W, encoded code of the selected key, registered.
- pak, output, 1, "pressed any key": registered OR-reduction of keys.

Behaviour:
- Reset: while rst=1 at a rising edge, char<=8'h00 and pak<=0. rst has priority over keys.
- Latency: exactly 1 cycle. keys sampled at edge k appear on char/pak after edge k. No handshake; a new result is produced every cycle.
- Encoding: char = index of the highest-numbered asserted bit of keys (MSB priority).
- Multi-hot input: highest index wins, e.g. keys[97] and keys[10] both set gives 8'h61.
- No keys asserted: char=8'h00 and pak=0.
- NUL versus nothing pressed: keys[0] alone gives char=8'h00 with pak=1. pak is the only way to tell NUL from no key.
- Combinational structure: 16 groups of 16 lines.
  - Each group yields a 4-bit local index and a group-valid bit.
  - A second-level 16-input priority stage selects the highest valid group, giving the upper nibble.
  - The selected group's local index gives the lower nibble.
- pak is computed as the OR of the 16 group-valid bits.
- Outputs hold while keys is stable. No latching of past presses: releasing all keys returns char=0 and pak=0 one cycle later.

Optional Feature:
- Macro: KEY_ENCODER_MULTI_DET_EN.
- When defined:
  - Adds output port multi (1 bit), registered with the same 1-cycle latency.
  - multi=1 when two or more bits of keys are asserted; reset value 0.
  - char and pak behaviour is unchanged.
- When undefined: the port and its logic are absent.

Decomposition:
- Shared package key_pkg holds:
  - N_IN and CODE_W constants.
  - Named localparams for the codes used by the bench and by consumers: KEY_NUL=0, KEY_LF=10, KEY_OP=40 '(', KEY_CP=41 ')', KEY_A_LC=97, KEY_B_LC=98, KEY_S_LC=115, KEY_X_LC=120.
- One sub-module, prio_enc16: 16-bit input, 4-bit index of the highest set bit, plus a valid output.
  - Instantiated 16 times at level one and once at level two.
  - Purely combinational.

Test Plan:
- Reset: assert rst with keys[97]=1 -> char=8'h00, pak=0. After rst drops, one edge later -> char=8'h61, pak=1.
- Single keys, each held one cycle, then all zero:
  - keys[97] -> 8'h61, keys[98] -> 8'h62, keys[115] -> 8'h73.
  - keys[40] -> 8'h28, keys[120] -> 8'h78, keys[41] -> 8'h29, keys[10] -> 8'h0A.
  - Each with pak=1; after the all-zero cycle -> char=8'h00, pak=0.
- NUL: keys[0]=1 -> char=8'h00, pak=1.
- Priority:
  - keys[97] and keys[10] -> 8'h61.
  - keys[255] and keys[0] -> 8'hFF.
  - With KEY_ENCODER_MULTI_DET_EN, both cases also give multi=1.
- Group boundaries: walk a single 1 through bits 15, 16, 127, 128, 240, 255 -> char equals the index each time, pak=1, multi=0.
- Latency: change keys every cycle (random one-hot) -> char always equals the previous cycle's index. rst pulsed mid-stream forces char=0 and pak=0 for that cycle only.
